hazard_ctrl: RTL

Pipeline control unit for the 5-stage CPU. Every cycle it decides whether the PC and the IF/ID register advance, hold or flush, and whether the ID/EX register is flushed or held. It covers load-use hazards, taken branches resolved in EX, jumps resolved in ID, and multi-cycle multiply/divide (MDU) operations that occupy EX. It drives the `IF_ID_wr_en` / `IF_ID_flush` inputs of the IF/ID pipeline register directly and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : 5-stage pipeline hazard/stall/flush control with MDU wait FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int unsigned MDU_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rt,
  input  logic        ID_jump,
  input  logic        EX_mem_read,
  input  logic [4:0]  EX_rt,
  input  logic        EX_branch_taken,
  input  logic        EX_mdu_start,
  output logic        PC_wr_en,
  output logic        IF_ID_wr_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_stall,
  output logic        busy,
  output logic [15:0] stall_count
);

  localparam logic [7:0]  c_MDU_LOAD = 8'(MDU_CYCLES - 1);
  localparam logic [15:0] c_SC_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_stall_count;
  logic        w_load_use;

  assign w_load_use = EX_mem_read && (EX_rt != 5'd0) &&
                      ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= 8'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!PC_wr_en && (r_stall_count != c_SC_MAX))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    PC_wr_en    = 1'b1;
    IF_ID_wr_en = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    EX_stall    = 1'b0;
    busy        = 1'b0;

    if (reset) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = 8'd0;
      PC_wr_en    = 1'b0;
      IF_ID_wr_en = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      case (r_state)
        MDU_WAIT: begin
          PC_wr_en    = 1'b0;
          IF_ID_wr_en = 1'b0;
          EX_stall    = 1'b1;
          busy        = 1'b1;
          w_cnt_nxt   = r_cnt - 8'd1;
          if (r_cnt == 8'd1)
            w_state_nxt = MDU_DONE;
        end
        default: begin
          // MDU_DONE always hands back to RUN; the finished op leaves EX now
          if (r_state == MDU_DONE)
            w_state_nxt = RUN;
          if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (EX_mdu_start && (r_state == RUN)) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            EX_stall    = 1'b1;
            w_state_nxt = MDU_WAIT;
            w_cnt_nxt   = c_MDU_LOAD;
          end else if (w_load_use) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            ID_EX_flush = 1'b1;
          end else if (ID_jump) begin
            IF_ID_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire
